// File: rtl/timer_ctrl_if.sv
// Signal bundle between the countdown sequencer and its surroundings (KEY inputs, timer datapath).
// The slave side is the sequencer. The master side drives the buttons, presets and timer_done.
interface timer_ctrl_if;
  logic       btn_start;
  logic       btn_pause;
  logic [3:0] preset_tens;
  logic [3:0] preset_ones;
  logic       timer_done;
  logic       tmr_load;
  logic [3:0] tmr_tens;
  logic [3:0] tmr_ones;
  logic       tmr_tick;
  logic       alarm;
  logic       preset_err;
  logic [3:0] round_idx;
  logic [2:0] state;

  modport slave (
    input  btn_start, btn_pause, preset_tens, preset_ones, timer_done,
    output tmr_load, tmr_tens, tmr_ones, tmr_tick, alarm, preset_err, round_idx, state
  );

  modport master (
    output btn_start, btn_pause, preset_tens, preset_ones, timer_done,
    input  tmr_load, tmr_tens, tmr_ones, tmr_tick, alarm, preset_err, round_idx, state
  );
endinterface

// File: rtl/timer_ctrl.sv
// Sequencer for the two-digit BCD countdown timer: button edges to load/tick pulses,
// tick prescaler, multi-round re-arm and a timed alarm. Every output comes from a register.
module timer_ctrl #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned NUM_ROUNDS   = 1,
  parameter int unsigned ALARM_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  timer_ctrl_if.slave bus
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AlarmW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [PrescW-1:0] PrescMax  = PrescW'(TICK_DIV - 1);
  localparam logic [AlarmW-1:0] AlarmMax  = AlarmW'(ALARM_CYCLES - 1);
  localparam logic [3:0]        LastRound = 4'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StAlarm = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                start_prev_q, pause_prev_q;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [AlarmW-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic [3:0]          round_q, round_d;
  logic [3:0]          tens_q, tens_d;
  logic [3:0]          ones_q, ones_d;
  logic                load_q, load_d;
  logic                tick_q, tick_d;
  logic                alarm_q, alarm_d;
  logic                err_q, err_d;

  logic start_press, pause_press, preset_ok;

  assign start_press = bus.btn_start & ~start_prev_q;
  assign pause_press = bus.btn_pause & ~pause_prev_q;
  assign preset_ok   = (bus.preset_tens <= 4'd9) && (bus.preset_ones <= 4'd9) &&
                       !((bus.preset_tens == 4'd0) && (bus.preset_ones == 4'd0));

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    alarm_cnt_d = '0;
    round_d     = round_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    err_d       = 1'b0;
    tick_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_press) begin
          if (preset_ok) begin
            state_d = StLoad;
            round_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        presc_d = '0;
        state_d = StRun;
      end
      StRun: begin
        if (bus.timer_done && (round_q < LastRound)) begin
          round_d = round_q + 4'd1;
          state_d = StLoad;
        end else if (bus.timer_done) begin
          state_d = StAlarm;
        end else if (pause_press) begin
          state_d = StPause;
        end
        // Leaving on the wrap cycle holds the prescaler at max so the tick fires after resume.
        if (presc_q == PrescMax) begin
          if (state_d == StRun) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StPause: begin
        if (start_press) begin
          round_d = '0;
          state_d = StLoad;
        end else if (pause_press) begin
          state_d = StRun;
        end
      end
      StAlarm: begin
        alarm_cnt_d = alarm_cnt_q + 1'b1;
        if ((alarm_cnt_q == AlarmMax) || start_press || pause_press) begin
          state_d     = StIdle;
          round_d     = '0;
          alarm_cnt_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        round_d = '0;
      end
    endcase

    // LOAD is one cycle long, so state_d == StLoad only on entry.
    if (state_d == StLoad) begin
      tens_d = bus.preset_tens;
      ones_d = bus.preset_ones;
    end

    load_d  = (state_d == StLoad);
    alarm_d = (state_d == StAlarm);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
      presc_q      <= '0;
      alarm_cnt_q  <= '0;
      round_q      <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
      load_q       <= 1'b0;
      tick_q       <= 1'b0;
      alarm_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.btn_start;
      pause_prev_q <= bus.btn_pause;
      presc_q      <= presc_d;
      alarm_cnt_q  <= alarm_cnt_d;
      round_q      <= round_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      load_q       <= load_d;
      tick_q       <= tick_d;
      alarm_q      <= alarm_d;
      err_q        <= err_d;
    end
  end

  assign bus.tmr_load   = load_q;
  assign bus.tmr_tens   = tens_q;
  assign bus.tmr_ones   = ones_q;
  assign bus.tmr_tick   = tick_q;
  assign bus.alarm      = alarm_q;
  assign bus.preset_err = err_q;
  assign bus.round_idx  = round_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4, NUM_ROUNDS=2, ALARM_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_timer_ctrl;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned NUM_ROUNDS   = 2;
  localparam int unsigned ALARM_CYCLES = 8;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  timer_ctrl_if bus ();

  timer_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .NUM_ROUNDS  (NUM_ROUNDS),
    .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.btn_start   = 1'b0;
    bus.btn_pause   = 1'b0;
    bus.timer_done  = 1'b0;
    bus.preset_tens = 4'd0;
    bus.preset_ones = 4'd3;
  endtask

  // Ends one cycle after release with idle buttons, so edge history is 0.
  task automatic do_reset();
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // Ends in the RUN entry cycle.
  task automatic start_to_run(input logic [3:0] tens, input logic [3:0] ones);
    bus.preset_tens = tens;
    bus.preset_ones = ones;
    bus.btn_start   = 1'b1;
    step();
    bus.btn_start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    outs = {bus.tmr_load, bus.tmr_tens, bus.tmr_ones, bus.tmr_tick, bus.alarm,
            bus.preset_err, bus.round_idx, bus.state};
    vectors++;
    if (outs !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %0h want 0", outs);
    end
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (bus.state !== 3'd0 || bus.tmr_load !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got state %0d load %0b want state 0 load 0",
               bus.state, bus.tmr_load);
    end
  endtask

  task automatic test_load_run();
    bus.preset_tens = 4'd0;
    bus.preset_ones = 4'd3;
    bus.btn_start   = 1'b1;
    step();
    bus.btn_start = 1'b0;
    vectors++;
    if (bus.tmr_load !== 1'b1 || bus.tmr_tens !== 4'd0 || bus.tmr_ones !== 4'd3 ||
        bus.state !== 3'd1) begin
      miscompares++;
      $display("FAIL load_pulse: got load %0b tens %0d ones %0d state %0d want 1 0 3 1",
               bus.tmr_load, bus.tmr_tens, bus.tmr_ones, bus.state);
    end
    bus.preset_tens = 4'd9;
    bus.preset_ones = 4'd9;
    step();
    vectors++;
    if (bus.state !== 3'd2 || bus.tmr_load !== 1'b0 || bus.tmr_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL run_entry: got state %0d load %0b tick %0b want 2 0 0",
               bus.state, bus.tmr_load, bus.tmr_tick);
    end
    vectors++;
    if (bus.tmr_tens !== 4'd0 || bus.tmr_ones !== 4'd3) begin
      miscompares++;
      $display("FAIL load_value_held: got %0d%0d want 03", bus.tmr_tens, bus.tmr_ones);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if (bus.tmr_tick !== ((i % 4) == 0)) begin
        miscompares++;
        $display("FAIL tick_cycle_%0d: got %0b want %0b", i, bus.tmr_tick, (i % 4) == 0);
      end
    end
  endtask

  // Continues from the third tick of test_load_run.
  task automatic test_rounds();
    int n;
    bus.timer_done = 1'b1;
    step();
    bus.timer_done = 1'b0;
    vectors++;
    if (bus.state !== 3'd1 || bus.tmr_load !== 1'b1 || bus.round_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL round_advance: got state %0d load %0b round %0d want 1 1 1",
               bus.state, bus.tmr_load, bus.round_idx);
    end
    vectors++;
    if (bus.tmr_tens !== 4'd9 || bus.tmr_ones !== 4'd9) begin
      miscompares++;
      $display("FAIL round_reload_value: got %0d%0d want 99", bus.tmr_tens, bus.tmr_ones);
    end
    step();
    step();
    step();
    bus.timer_done = 1'b1;
    step();
    bus.timer_done = 1'b0;
    vectors++;
    if (bus.state !== 3'd4 || bus.alarm !== 1'b1 || bus.round_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL alarm_entry: got state %0d alarm %0b round %0d want 4 1 1",
               bus.state, bus.alarm, bus.round_idx);
    end
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.alarm !== 1'b1) break;
      n++;
      step();
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL alarm_length: got %0d cycles want 8", n);
    end
    vectors++;
    if (bus.state !== 3'd0 || bus.round_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL alarm_exit: got state %0d round %0d want 0 0", bus.state, bus.round_idx);
    end
  endtask

  task automatic test_pause();
    int ticks;
    do_reset();
    start_to_run(4'd0, 4'd3);
    for (int i = 1; i <= 4; i++) step();
    vectors++;
    if (bus.tmr_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_first_tick: got %0b want 1", bus.tmr_tick);
    end
    step();
    step();
    bus.btn_pause = 1'b1;
    step();
    bus.btn_pause = 1'b0;
    vectors++;
    if (bus.state !== 3'd3 || bus.tmr_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_entry: got state %0d tick %0b want 3 0", bus.state, bus.tmr_tick);
    end
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.tmr_tick === 1'b1) ticks++;
    end
    vectors++;
    if (ticks != 0 || bus.state !== 3'd3) begin
      miscompares++;
      $display("FAIL paused_no_tick: got %0d ticks state %0d want 0 ticks state 3",
               ticks, bus.state);
    end
    bus.btn_pause = 1'b1;
    step();
    bus.btn_pause = 1'b0;
    vectors++;
    if (bus.state !== 3'd2 || bus.tmr_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL resume: got state %0d tick %0b want 2 0", bus.state, bus.tmr_tick);
    end
    step();
    vectors++;
    if (bus.tmr_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL resume_tick: got %0b want 1", bus.tmr_tick);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++;
      if (bus.tmr_tick !== (i == 4)) begin
        miscompares++;
        $display("FAIL post_resume_tick_%0d: got %0b want %0b", i, bus.tmr_tick, i == 4);
      end
    end
  endtask

  task automatic test_errors();
    logic [7:0] bad [3];
    bad[0] = 8'h00;
    bad[1] = 8'h0A;
    bad[2] = 8'hA1;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      bus.preset_tens = bad[b][7:4];
      bus.preset_ones = bad[b][3:0];
      bus.btn_start   = 1'b1;
      step();
      bus.btn_start = 1'b0;
      vectors++;
      if (bus.preset_err !== 1'b1 || bus.tmr_load !== 1'b0 || bus.state !== 3'd0) begin
        miscompares++;
        $display("FAIL preset_err_%0h: got err %0b load %0b state %0d want 1 0 0",
                 bad[b], bus.preset_err, bus.tmr_load, bus.state);
      end
      step();
      vectors++;
      if (bus.preset_err !== 1'b0 || bus.state !== 3'd0) begin
        miscompares++;
        $display("FAIL preset_err_len_%0h: got err %0b state %0d want 0 0",
                 bad[b], bus.preset_err, bus.state);
      end
    end
    bus.btn_pause  = 1'b1;
    bus.timer_done = 1'b1;
    step();
    bus.btn_pause  = 1'b0;
    bus.timer_done = 1'b0;
    vectors++;
    if (bus.state !== 3'd0 || bus.preset_err !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignores_pause_done: got state %0d err %0b want 0 0",
               bus.state, bus.preset_err);
    end
  endtask

  task automatic test_priority();
    do_reset();
    start_to_run(4'd0, 4'd3);
    step();
    bus.timer_done = 1'b1;
    bus.btn_pause  = 1'b1;
    step();
    bus.timer_done = 1'b0;
    bus.btn_pause  = 1'b0;
    vectors++;
    if (bus.state !== 3'd1 || bus.round_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL done_beats_pause: got state %0d round %0d want 1 1",
               bus.state, bus.round_idx);
    end
    step();
    bus.btn_pause = 1'b1;
    step();
    bus.btn_pause = 1'b0;
    vectors++;
    if (bus.state !== 3'd3) begin
      miscompares++;
      $display("FAIL priority_pause: got state %0d want 3", bus.state);
    end
    step();
    bus.preset_tens = 4'd1;
    bus.preset_ones = 4'd2;
    bus.btn_start   = 1'b1;
    bus.btn_pause   = 1'b1;
    step();
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    vectors++;
    if (bus.state !== 3'd1 || bus.tmr_load !== 1'b1 || bus.round_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL start_beats_pause: got state %0d load %0b round %0d want 1 1 0",
               bus.state, bus.tmr_load, bus.round_idx);
    end
    vectors++;
    if (bus.tmr_tens !== 4'd1 || bus.tmr_ones !== 4'd2) begin
      miscompares++;
      $display("FAIL restart_value: got %0d%0d want 12", bus.tmr_tens, bus.tmr_ones);
    end
  endtask

  task automatic test_start_held();
    int loads;
    step();
    idle_inputs();
    reset         = 1'b1;
    bus.btn_start = 1'b1;
    step();
    step();
    reset = 1'b0;
    loads = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.tmr_load === 1'b1) loads++;
    end
    vectors++;
    if (loads != 0 || bus.state !== 3'd0) begin
      miscompares++;
      $display("FAIL start_held_through_reset: got %0d loads state %0d want 0 loads state 0",
               loads, bus.state);
    end
    bus.btn_start = 1'b0;
    step();
    bus.btn_start = 1'b1;
    step();
    bus.btn_start = 1'b0;
    vectors++;
    if (bus.tmr_load !== 1'b1) begin
      miscompares++;
      $display("FAIL start_after_held: got load %0b want 1", bus.tmr_load);
    end
  endtask

  task automatic test_async_reset();
    logic [18:0] outs;
    do_reset();
    start_to_run(4'd5, 4'd7);
    step();
    step();
    vectors++;
    if (bus.state !== 3'd2 || bus.tmr_tens !== 4'd5) begin
      miscompares++;
      $display("FAIL pre_reset_run: got state %0d tens %0d want 2 5", bus.state, bus.tmr_tens);
    end
    #3;
    reset = 1'b1;
    #1;
    outs = {bus.tmr_load, bus.tmr_tens, bus.tmr_ones, bus.tmr_tick, bus.alarm,
            bus.preset_err, bus.round_idx, bus.state};
    vectors++;
    if (outs !== 19'd0) begin
      miscompares++;
      $display("FAIL async_reset_run: got %0h want 0", outs);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    start_to_run(4'd0, 4'd1);
    bus.timer_done = 1'b1;
    step();
    bus.timer_done = 1'b0;
    step();
    bus.timer_done = 1'b1;
    step();
    bus.timer_done = 1'b0;
    step();
    step();
    vectors++;
    if (bus.alarm !== 1'b1 || bus.state !== 3'd4) begin
      miscompares++;
      $display("FAIL pre_reset_alarm: got alarm %0b state %0d want 1 4", bus.alarm, bus.state);
    end
    #3;
    reset = 1'b1;
    #1;
    outs = {bus.tmr_load, bus.tmr_tens, bus.tmr_ones, bus.tmr_tick, bus.alarm,
            bus.preset_err, bus.round_idx, bus.state};
    vectors++;
    if (outs !== 19'd0) begin
      miscompares++;
      $display("FAIL async_reset_alarm: got %0h want 0", outs);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    bus.preset_tens = 4'd0;
    bus.preset_ones = 4'd3;
    bus.btn_start   = 1'b1;
    step();
    bus.btn_start = 1'b0;
    vectors++;
    if (bus.tmr_load !== 1'b1 || bus.state !== 3'd1 || bus.tmr_ones !== 4'd3) begin
      miscompares++;
      $display("FAIL start_after_reset: got load %0b state %0d ones %0d want 1 1 3",
               bus.tmr_load, bus.state, bus.tmr_ones);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_load_run();
    test_rounds();
    test_pause();
    test_errors();
    test_priority();
    test_start_held();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
